// File: rtl/rr_mux_n.sv
// N-to-1 stream multiplexer with a registered output stage.
// Fixed-select or round-robin grant, per-channel valid/ready handshakes.
module rr_mux_n #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_i,
    input  logic [SELW-1:0]   sel_i,
    input  logic [N*W-1:0]    in_data_i,
    input  logic [N-1:0]      in_valid_i,
    output logic [N-1:0]      in_ready_o,
    output logic [W-1:0]      out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SELW-1:0]   out_ch_o
);

    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load_en;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] cand;
    logic            xfer;

    assign load_en = !out_valid_q || out_ready_i;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!mode_i) begin
            if (32'(sel_i) < N && in_valid_i[sel_i]) begin
                grant_vld = 1'b1;
                grant_idx = sel_i;
            end
        end else begin
            // Scan starts just after the last-served channel so every requester gets a turn.
            for (int unsigned i = 1; i <= N; i++) begin
                cand = SELW'((32'(ptr_q) + i) % N);
                if (!grant_vld && in_valid_i[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Reset gates the grant so no producer sees a handshake while the stage is being cleared.
    assign xfer = load_en && grant_vld && !rst;

    always_comb begin
        in_ready_o = '0;
        if (xfer) begin
            in_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = in_data_i[32'(grant_idx) * W +: W];
            out_valid_d = 1'b1;
            out_ch_d    = grant_idx;
            ptr_d       = grant_idx;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: a 4-channel instance and a 3-channel instance.
module tb_rr_mux_n;

    logic clk;
    logic rst;

    logic        a_mode;
    logic [1:0]  a_sel;
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [1:0]  a_out_ch;

    logic        b_mode;
    logic [1:0]  b_sel;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_ch;

    int n_total;
    int n_bad;

    rr_mux_n #(.N(4), .W(8)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (a_mode),
        .sel_i       (a_sel),
        .in_data_i   (a_in_data),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .out_data_o  (a_out_data),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_ch_o    (a_out_ch)
    );

    rr_mux_n #(.N(3), .W(8)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (b_mode),
        .sel_i       (b_sel),
        .in_data_i   (b_in_data),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .out_data_o  (b_out_data),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_ch_o    (b_out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq_a [4];
        logic [1:0] seq_b [4];
        n_total = 0;
        n_bad   = 0;

        rst         = 1'b1;
        a_mode      = 1'b1;
        a_sel       = 2'd0;
        a_in_data   = 32'h44332211;
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        b_mode      = 1'b0;
        b_sel       = 2'd0;
        b_in_data   = 24'h776655;
        b_in_valid  = 3'b000;
        b_out_ready = 1'b1;
        step();
        step();
        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_data", 32'(a_out_data), 32'd0);
        check("rst_ch", 32'(a_out_ch), 32'd0);
        check("rst_ready", 32'(a_in_ready), 32'd0);

        // Round-robin with all channels valid: 0,1,2,3,0,1,2,3.
        rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_ready", 32'(a_in_ready), 32'(4'b0001 << (k % 4)));
            step();
            check("rr_ch", 32'(a_out_ch), 32'(k % 4));
            check("rr_valid", 32'(a_out_valid), 32'd1);
            check("rr_data", 32'(a_out_data), 32'((k % 4 + 1) * 8'h11));
        end

        // Sparse requesters: only channels 1 and 3.
        a_in_valid = 4'b1010;
        seq_a[0] = 2'd1; seq_a[1] = 2'd3; seq_a[2] = 2'd1; seq_a[3] = 2'd3;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_sparse_ch", 32'(a_out_ch), 32'(seq_a[k]));
            check("rr_sparse_valid", 32'(a_out_valid), 32'd1);
        end

        // Backpressure holds word (ch3, 44) and pointer.
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 32'(a_in_ready), 32'd0);
            step();
            check("bp_data", 32'(a_out_data), 32'h44);
            check("bp_ch", 32'(a_out_ch), 32'd3);
            check("bp_valid", 32'(a_out_valid), 32'd1);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 32'b0001);
        step();
        check("bp_release_ch", 32'(a_out_ch), 32'd0);
        check("bp_release_valid", 32'(a_out_valid), 32'd1);
        check("bp_release_data", 32'(a_out_data), 32'h11);

        // Fixed mode select 2.
        a_mode = 1'b0;
        a_sel  = 2'd2;
        #1;
        check("fix_ready", 32'(a_in_ready), 32'b0100);
        step();
        check("fix_data", 32'(a_out_data), 32'h33);
        check("fix_ch", 32'(a_out_ch), 32'd2);
        a_in_valid = 4'b1011;
        #1;
        check("fix_novalid_ready", 32'(a_in_ready), 32'd0);
        step();
        check("fix_drain_valid", 32'(a_out_valid), 32'd0);
        check("fix_hold_data", 32'(a_out_data), 32'h33);
        check("fix_hold_ch", 32'(a_out_ch), 32'd2);

        // Switching to round-robin continues after channel 2.
        a_mode     = 1'b1;
        a_in_valid = 4'b1111;
        #1;
        check("sw_ready", 32'(a_in_ready), 32'b1000);
        step();
        check("sw_ch", 32'(a_out_ch), 32'd3);
        check("sw_data", 32'(a_out_data), 32'h44);

        // Reset mid-stream with a pending word.
        a_out_ready = 1'b0;
        step();
        check("pre_rst_valid", 32'(a_out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_data", 32'(a_out_data), 32'd0);
        check("mid_rst_ch", 32'(a_out_ch), 32'd0);
        check("mid_rst_ready", 32'(a_in_ready), 32'd0);
        step();
        rst         = 1'b0;
        a_out_ready = 1'b1;
        #1;
        check("post_rst_ready", 32'(a_in_ready), 32'b0001);
        step();
        check("post_rst_ch", 32'(a_out_ch), 32'd0);
        check("post_rst_valid", 32'(a_out_valid), 32'd1);

        // N=3: pointer wraps 2 -> 0.
        b_mode     = 1'b1;
        b_in_valid = 3'b111;
        seq_b[0] = 2'd0; seq_b[1] = 2'd1; seq_b[2] = 2'd2; seq_b[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("n3_ch", 32'(b_out_ch), 32'(seq_b[k]));
            check("n3_data", 32'(b_out_data), 32'(8'h55 + 8'(seq_b[k]) * 8'h11));
        end
        b_mode = 1'b0;
        b_sel  = 2'd3;
        #1;
        check("n3_sel3_ready", 32'(b_in_ready), 32'd0);
        step();
        check("n3_sel3_drain", 32'(b_out_valid), 32'd0);
        b_sel = 2'd2;
        #1;
        check("n3_sel2_ready", 32'(b_in_ready), 32'b100);
        step();
        check("n3_sel2_ch", 32'(b_out_ch), 32'd2);
        check("n3_sel2_data", 32'(b_out_data), 32'h77);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
